rtc_cmd_scheduler: RTL and testbench
====================================

Name: rtc_cmd_scheduler

Overview:
- Upstream command source for the RTC read/write controller.
- Latches user write requests and generates the periodic read request.
- Arbitrates requests by fixed priority. Issues exactly one single-cycle command pulse at a time, then waits for the controller's ready pulse before issuing the next.
- Issues the power-up init command automatically after reset.

Parameters:
- READ_PERIOD, 10000000: clk cycles between automatic read requests (100 ms at 100 MHz); must be >= 2.
- CNT_W, 24: width of the read-period counter; 2^CNT_W must be > READ_PERIOD.
- TIMEOUT_CYCLES, 4096: WAIT cycles before a command is abandoned (used only with the optional feature).

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- req_hora in 1: 1-cycle pulse from UI, time registers edited.
- req_fecha in 1: 1-cycle pulse from UI, date registers edited.
- req_timer in 1: 1-cycle pulse from UI, timer registers edited.
- req_stop_ring in 1: 1-cycle pulse from UI, silence the alarm.
- ready in 1: 1-cycle done pulse from the read/write controller.
- inic out 1: command pulse, initialise RTC.
- stop_ring out 1: command pulse, clear the alarm/timer flag.
- esc_hora out 1: command pulse, write time.
- esc_fecha out 1: command pulse, write date.
- esc_timer out 1: command pulse, write timer.
- leer out 1: command pulse, read all registers.
- busy out 1: high from the command pulse until the transaction ends.
- pend out 6: pending flags {inic, stop_ring, hora, fecha, timer, leer}.
- cmd_done out 1: 1-cycle pulse when a transaction completes.
- err out 1: sticky timeout flag (0 when feature disabled).

Behaviour:
- Reset (async, any state): state=INIT; all command outputs, busy, cmd_done, err = 0; pend=6'b100000; read counter=0.
- Pending latch: a req_* pulse sets its pend bit on the next edge. Set wins over a same-cycle clear. A request while already pending is absorbed (one command issued). A request for the command currently in flight re-sets its bit, so the write is reissued afterwards.
- Read counter: free-runs in all states, counts 0..READ_PERIOD-1 and wraps. At the wrap edge it sets pend[0]; absorbed if already set.
- Priority, highest first: inic > stop_ring > esc_hora > esc_fecha > esc_timer > leer.
- States:
  - INIT: next edge -> IDLE. inic is already pending and is served first.
  - IDLE: if pend != 0, then at the edge assert exactly the highest-priority command output (registered), clear its pend bit, set busy, go WAIT. Otherwise stay in IDLE.
  - WAIT: command output is high only in the first WAIT cycle, then 0. ready is sampled only in WAIT, including the first cycle. On ready: busy=0, cmd_done=1 for one cycle, go GAP.
  - GAP: one guard cycle; cmd_done returns to 0; next edge -> IDLE.
- ready asserted in IDLE, INIT or GAP is ignored.
- Latency:
  - req pulse in cycle t -> pend bit high in t+1 -> command pulse in t+2 (when idle and highest priority).
  - ready in cycle t -> earliest next command in t+3.
- At most one command output is high in any cycle. Command outputs are never high while busy was already high in the previous cycle.
- Reset mid-transaction: all flags lost except inic, which is re-armed. The first command after reset is always inic.

Optional Feature:
- Macro RTC_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter (clog2(TIMEOUT_CYCLES)+1 bits) is cleared on entry to WAIT.
  - If TIMEOUT_CYCLES cycles elapse without ready: err=1 (sticky until reset), busy=0, cmd_done stays 0, go GAP.
  - The abandoned command's pend bit is not restored; the next periodic read proceeds normally.
- Not defined: no counter; WAIT holds until ready indefinitely; err tied to 0.

Test Plan:
- Reset release, ready 3 cycles after pulse -> inic high exactly 1 cycle at cycle 1 after INIT, pend=000000 after, cmd_done 1 cycle after ready, busy low.
- READ_PERIOD=20, no requests, ready 5 cycles after each pulse -> leer pulses every 20 cycles, no other outputs toggle.
- During a leer WAIT, pulse req_timer, req_hora, req_stop_ring together -> after ready, order stop_ring, esc_hora, esc_timer; each issued only after the previous ready.
- req_hora pulsed 3 times while a command is in flight -> exactly one esc_hora issued; req_hora during the esc_hora WAIT -> second esc_hora issued after it.
- ready held permanently high in IDLE -> no cmd_done; ready pulse in the first WAIT cycle -> cmd_done next cycle.
- RTC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, ready never asserted -> err=1 and busy=0 50 cycles after pulse; next leer still issued. Async reset mid-WAIT -> all outputs 0 immediately, then inic issued.

Source files
------------

// File: rtl/rtc_cmd_scheduler_if.sv
// Command/handshake bundle between the RTC command scheduler and its UI/controller peers.
// master: the scheduler (issues commands); slave: the UI and read/write controller side.
interface rtc_cmd_scheduler_if;
  logic       req_hora;
  logic       req_fecha;
  logic       req_timer;
  logic       req_stop_ring;
  logic       ready;
  logic       inic;
  logic       stop_ring;
  logic       esc_hora;
  logic       esc_fecha;
  logic       esc_timer;
  logic       leer;
  logic       busy;
  logic [5:0] pend;
  logic       cmd_done;
  logic       err;

  modport master (
    input  req_hora, req_fecha, req_timer, req_stop_ring, ready,
    output inic, stop_ring, esc_hora, esc_fecha, esc_timer, leer, busy, pend, cmd_done, err
  );

  modport slave (
    output req_hora, req_fecha, req_timer, req_stop_ring, ready,
    input  inic, stop_ring, esc_hora, esc_fecha, esc_timer, leer, busy, pend, cmd_done, err
  );
endinterface

// File: rtl/rtc_cmd_scheduler.sv
// Fixed-priority command scheduler for the RTC read/write controller: one command in flight.
// Define RTC_SCHED_TIMEOUT_EN to abandon commands whose ready never arrives (sets sticky err).
module rtc_cmd_scheduler #(
  parameter int unsigned READ_PERIOD    = 10000000,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  rtc_cmd_scheduler_if.master        bus_io
);

  typedef enum logic [1:0] {StInit, StIdle, StWait, StGap} state_e;

  state_e           state_q;
  logic [5:0]       pend_q, pend_d;
  logic [5:0]       cmd_q;
  logic [5:0]       grant;
  logic             busy_q, done_q, err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_wrap;
  logic             issue;
  logic             tmo;

  assign cnt_wrap = (cnt_q == CNT_W'(READ_PERIOD - 1));
  assign cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
  assign issue    = (state_q == StIdle) && (pend_q != 6'd0);

  // Bit 5 is highest priority; later iterations overwrite lower winners.
  always_comb begin
    grant = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (pend_q[i]) grant = 6'd1 << i;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (issue) pend_d = pend_d & ~grant;
    pend_d = pend_d | {1'b0, bus_io.req_stop_ring, bus_io.req_hora, bus_io.req_fecha,
                       bus_io.req_timer, cnt_wrap};
  end

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt_q;

  assign tmo = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tcnt_q <= '0;
    end else if (issue) begin
      tcnt_q <= '0;
    end else if (state_q == StWait) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StInit;
      pend_q  <= 6'b100000;
      cnt_q   <= '0;
      cmd_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      cmd_q  <= 6'd0;
      done_q <= 1'b0;
      unique case (state_q)
        StInit: state_q <= StIdle;
        StIdle: begin
          if (issue) begin
            cmd_q   <= grant;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus_io.ready) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StGap;
          end else if (tmo) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StGap;
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.inic      = cmd_q[5];
  assign bus_io.stop_ring = cmd_q[4];
  assign bus_io.esc_hora  = cmd_q[3];
  assign bus_io.esc_fecha = cmd_q[2];
  assign bus_io.esc_timer = cmd_q[1];
  assign bus_io.leer      = cmd_q[0];
  assign bus_io.busy      = busy_q;
  assign bus_io.pend      = pend_q;
  assign bus_io.cmd_done  = done_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_rtc_cmd_scheduler.sv
// Directed bench for rtc_cmd_scheduler with READ_PERIOD=20, TIMEOUT_CYCLES=50.
// Cycle numbers are counted from the first cycle after reset release (cycle 0 = INIT).
module tb_rtc_cmd_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   p;
  int   base;

  localparam logic [5:0] CInic = 6'b100000;
  localparam logic [5:0] CStop = 6'b010000;
  localparam logic [5:0] CHora = 6'b001000;
  localparam logic [5:0] CFech = 6'b000100;
  localparam logic [5:0] CTimr = 6'b000010;
  localparam logic [5:0] CLeer = 6'b000001;

  rtc_cmd_scheduler_if bus ();

  rtc_cmd_scheduler #(
    .READ_PERIOD   (20),
    .CNT_W         (8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] cmd_vec;
  assign cmd_vec = {bus.inic, bus.stop_ring, bus.esc_hora, bus.esc_fecha, bus.esc_timer, bus.leer};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cmd(input logic [5:0] exp, input string tag, output int pc);
    int k = 0;
    while (cmd_vec == 6'd0 && k < 100) begin
      step();
      k++;
    end
    pc = cyc;
    chk({tag, " cmd"}, 32'(cmd_vec), 32'(exp));
    chk({tag, " busy"}, 32'(bus.busy), 1);
  endtask

  // Answer with ready d cycles after the pulse, then check completion and the guard cycle.
  task automatic finish_cmd(input int d, input string tag);
    if (d == 0) bus.ready = 1'b1;
    for (int k = 1; k <= d; k++) begin
      step();
      chk({tag, " quiet"}, 32'(cmd_vec), 0);
      chk({tag, " busy hold"}, 32'(bus.busy), 1);
      if (k == d) bus.ready = 1'b1;
    end
    step();
    bus.ready = 1'b0;
    chk({tag, " done"}, 32'(bus.cmd_done), 1);
    chk({tag, " busy off"}, 32'(bus.busy), 0);
    chk({tag, " gap quiet"}, 32'(cmd_vec), 0);
    step();
    chk({tag, " done drop"}, 32'(bus.cmd_done), 0);
  endtask

  initial begin
    bus.req_hora = 1'b0;
    bus.req_fecha = 1'b0;
    bus.req_timer = 1'b0;
    bus.req_stop_ring = 1'b0;
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Power-up init
    chk("reset pend", 32'(bus.pend), 32'(CInic));
    chk("reset cmd", 32'(cmd_vec), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset err", 32'(bus.err), 0);
    step();
    chk("c1 cmd", 32'(cmd_vec), 0);
    step();
    chk("c2 inic", 32'(cmd_vec), 32'(CInic));
    chk("c2 busy", 32'(bus.busy), 1);
    chk("c2 pend", 32'(bus.pend), 0);
    finish_cmd(3, "inic");
    chk("inic done cycle", cyc, 7);
    chk("post inic pend", 32'(bus.pend), 0);

    // Periodic reads every 20 cycles
    wait_cmd(CLeer, "leer1", p);
    chk("leer1 cycle", p, 21);
    finish_cmd(5, "leer1");
    wait_cmd(CLeer, "leer2", p);
    chk("leer2 cycle", p, 41);
    finish_cmd(5, "leer2");
    wait_cmd(CLeer, "leer3", p);
    chk("leer3 cycle", p, 61);
    finish_cmd(5, "leer3");

    // Three requests during a read WAIT, served in priority order
    wait_cmd(CLeer, "leer4", p);
    chk("leer4 cycle", p, 81);
    step();
    bus.req_timer = 1'b1;
    bus.req_hora = 1'b1;
    bus.req_stop_ring = 1'b1;
    step();
    bus.req_timer = 1'b0;
    bus.req_hora = 1'b0;
    bus.req_stop_ring = 1'b0;
    chk("multi pend", 32'(bus.pend), 32'(6'b011010));
    chk("multi quiet", 32'(cmd_vec), 0);
    step();
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    chk("leer4 done", 32'(bus.cmd_done), 1);
    step();
    wait_cmd(CStop, "stop", p);
    chk("stop cycle", p, 87);
    finish_cmd(2, "stop");
    wait_cmd(CHora, "hora", p);
    chk("hora cycle", p, 92);
    finish_cmd(2, "hora");
    wait_cmd(CTimr, "timer", p);
    chk("timer cycle", p, 97);
    finish_cmd(2, "timer");
    wait_cmd(CLeer, "leer5", p);
    chk("leer5 cycle", p, 102);
    finish_cmd(2, "leer5");

    // Repeated hora requests are absorbed; one during its own WAIT reissues it
    wait_cmd(CLeer, "leer6", p);
    chk("leer6 cycle", p, 121);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.req_hora = 1'b1;
      step();
      bus.req_hora = 1'b0;
      chk("absorb pend", 32'(bus.pend), 32'(CHora));
    end
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    chk("leer6 done", 32'(bus.cmd_done), 1);
    step();
    wait_cmd(CHora, "hora a", p);
    chk("hora a cycle", p, 130);
    step();
    bus.req_hora = 1'b1;
    step();
    bus.req_hora = 1'b0;
    chk("reissue pend", 32'(bus.pend), 32'(CHora));
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    chk("hora a done", 32'(bus.cmd_done), 1);
    step();
    wait_cmd(CHora, "hora b", p);
    chk("hora b cycle", p, 135);
    finish_cmd(1, "hora b");
    wait_cmd(CLeer, "leer7", p);
    chk("leer7 cycle", p, 141);
    finish_cmd(1, "leer7");

    // ready in IDLE is ignored; ready in the first WAIT cycle completes
    bus.ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("idle ready done", 32'(bus.cmd_done), 0);
      chk("idle ready busy", 32'(bus.busy), 0);
    end
    bus.ready = 1'b0;
    wait_cmd(CLeer, "leer8", p);
    chk("leer8 cycle", p, 161);
    finish_cmd(0, "leer8");

    // Missing ready
    wait_cmd(CLeer, "leer9", p);
    chk("leer9 cycle", p, 181);
`ifdef RTC_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 49; k++) begin
      step();
      chk("tmo busy", 32'(bus.busy), 1);
      chk("tmo err", 32'(bus.err), 0);
    end
    step();
    chk("tmo fire busy", 32'(bus.busy), 0);
    chk("tmo fire err", 32'(bus.err), 1);
    chk("tmo fire done", 32'(bus.cmd_done), 0);
    chk("tmo fire cycle", cyc, 231);
    step();
    chk("tmo err sticky", 32'(bus.err), 1);
    wait_cmd(CLeer, "leer10", p);
    chk("leer10 cycle", p, 233);
    finish_cmd(1, "leer10");
    chk("err still set", 32'(bus.err), 1);
`else
    finish_cmd(60, "long wait");
    chk("no err", 32'(bus.err), 0);
    wait_cmd(CLeer, "leer10", p);
    chk("leer10 cycle", p, 244);
    finish_cmd(1, "leer10");
`endif
    wait_cmd(CLeer, "drain", p);
    finish_cmd(1, "drain");
    base = cyc;
    chk("drain pend", 32'(bus.pend), 0);

    // fecha beats timer
    bus.req_fecha = 1'b1;
    bus.req_timer = 1'b1;
    step();
    bus.req_fecha = 1'b0;
    bus.req_timer = 1'b0;
    chk("ft pend", 32'(bus.pend), 32'(6'b000110));
    wait_cmd(CFech, "fecha", p);
    chk("fecha cycle", p, base + 2);
    finish_cmd(1, "fecha");
    wait_cmd(CTimr, "timer2", p);
    chk("timer2 cycle", p, base + 6);
    finish_cmd(1, "timer2");

    // Async reset in the middle of a WAIT
    bus.req_hora = 1'b1;
    bus.req_fecha = 1'b1;
    step();
    bus.req_hora = 1'b0;
    bus.req_fecha = 1'b0;
    step();
    chk("pre-reset hora", 32'(cmd_vec), 32'(CHora));
    chk("pre-reset pend", 32'(bus.pend), 32'(CFech));
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async cmd", 32'(cmd_vec), 0);
    chk("async busy", 32'(bus.busy), 0);
    chk("async done", 32'(bus.cmd_done), 0);
    chk("async err", 32'(bus.err), 0);
    chk("async pend", 32'(bus.pend), 32'(CInic));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("rerst c0 cmd", 32'(cmd_vec), 0);
    step();
    chk("rerst c1 cmd", 32'(cmd_vec), 0);
    step();
    chk("rerst inic", 32'(cmd_vec), 32'(CInic));
    chk("rerst pend", 32'(bus.pend), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
